hazard_ctrl: RTL and testbench

// - Pipeline sequencer for the 5-stage core (IF, IF_ID, ID_EX, EX_MEM, MEM_WB, write).
// - Tracks in-flight destination registers, detects RAW hazards and control hazards.
// - Drives stall and flush to the fetch stage and the pipeline registers.
// - Runs the branch-wait FSM, since PC redirect only arrives from write-back.

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and branch sequencer for the 5-stage core: RAW scoreboard, stall/bubble/flush and branch-wait FSM.
// Optional operand forwarding is compiled in when HAZARD_FWD_EN is defined.
module hazard_ctrl #(
   parameter int BR_LAT = 3,
   parameter int REG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wr,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_is_load,
   input  logic             id_is_branch,
   output logic             stall_if,
   output logic             bubble_ex,
   output logic             flush_if_id,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             br_busy
);

   localparam int CNT_W = (BR_LAT > 1) ? $clog2(BR_LAT) : 1;

   typedef enum logic [1:0] {IDLE, BR_WAIT, RESUME} state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt;

   // Scoreboard of in-flight destinations; only the EX slot needs the load flag.
   logic             ex_v, mem_v, wb_v;
   logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
   logic             ex_ld;

   logic use_a, use_b;
   logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
   logic hazard;
   logic [1:0] fwd_a_sel, fwd_b_sel;

   assign use_a     = id_valid & id_use_rs & (id_rs != '0);
   assign use_b     = id_valid & id_use_rt & (id_rt != '0);
   assign hit_ex_a  = ex_v  & (ex_rd  == id_rs) & use_a;
   assign hit_ex_b  = ex_v  & (ex_rd  == id_rt) & use_b;
   assign hit_mem_a = mem_v & (mem_rd == id_rs) & use_a;
   assign hit_mem_b = mem_v & (mem_rd == id_rt) & use_b;

`ifdef HAZARD_FWD_EN
   logic unused_wb;
   assign unused_wb = wb_v ^ (^wb_rd);

   // Only a load in EX cannot be forwarded yet; everything else is bypassed.
   assign hazard    = (hit_ex_a | hit_ex_b) & ex_ld;
   assign fwd_a_sel = (hit_ex_a & ~ex_ld) ? 2'd1 : (hit_mem_a ? 2'd2 : 2'd0);
   assign fwd_b_sel = (hit_ex_b & ~ex_ld) ? 2'd1 : (hit_mem_b ? 2'd2 : 2'd0);
`else
   logic hit_wb_a, hit_wb_b;
   logic unused_ld;
   assign unused_ld = ex_ld;
   assign hit_wb_a  = wb_v & (wb_rd == id_rs) & use_a;
   assign hit_wb_b  = wb_v & (wb_rd == id_rt) & use_b;
   assign hazard    = hit_ex_a | hit_ex_b | hit_mem_a | hit_mem_b | hit_wb_a | hit_wb_b;
   assign fwd_a_sel = 2'd0;
   assign fwd_b_sel = 2'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         ex_v  <= 1'b0;
         mem_v <= 1'b0;
         wb_v  <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && next_state == BR_WAIT)
            cnt <= CNT_W'(BR_LAT - 1);
         else if (state == BR_WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
         ex_v  <= id_valid & id_wr & ~bubble_ex & (id_rd != '0);
         mem_v <= ex_v;
         wb_v  <= mem_v;
      end
   end

   // Register indices and load flag travel unreset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      ex_rd  <= id_rd;
      ex_ld  <= id_is_load;
      mem_rd <= ex_rd;
      wb_rd  <= mem_rd;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (id_valid & id_is_branch & ~hazard) next_state = BR_WAIT;
         BR_WAIT: if (cnt == '0) next_state = RESUME;
         RESUME:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Hazard and forwarding only matter in IDLE; the branch states override them.
   always_comb begin
      stall_if    = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      fwd_a       = 2'd0;
      fwd_b       = 2'd0;
      br_busy     = 1'b0;
      case (state)
         IDLE: begin
            stall_if  = hazard;
            bubble_ex = hazard;
            fwd_a     = fwd_a_sel;
            fwd_b     = fwd_b_sel;
         end
         BR_WAIT: begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
            br_busy   = 1'b1;
         end
         RESUME: begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
            br_busy     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow HAZARD_FWD_EN when it is defined.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_use_rs, id_use_rt, id_wr, id_is_load, id_is_branch;
   logic       stall_if, bubble_ex, flush_if_id, br_busy;
   logic [1:0] fwd_a, fwd_b;

   int n_chk;
   int n_fail;

   hazard_ctrl #(.BR_LAT(3), .REG_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_wr        (id_wr),
      .id_rd        (id_rd),
      .id_is_load   (id_is_load),
      .id_is_branch (id_is_branch),
      .stall_if     (stall_if),
      .bubble_ex    (bubble_ex),
      .flush_if_id  (flush_if_id),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .br_busy      (br_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
      end
   endtask

   task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit wr, input int rd, input bit ld, input bit br);
      id_valid     = v;
      id_rs        = 5'(rs);
      id_rt        = 5'(rt);
      id_use_rs    = urs;
      id_use_rt    = urt;
      id_wr        = wr;
      id_rd        = 5'(rd);
      id_is_load   = ld;
      id_is_branch = br;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One cycle: check outputs mid-cycle for the current inputs, then cross the edge.
   task automatic expect_out(input string tag, input bit s, input bit b, input bit f,
                             input int fa, input int fb, input bit busy);
      @(negedge clk);
      chk({tag, ".stall_if"},    int'(stall_if),    int'(s));
      chk({tag, ".bubble_ex"},   int'(bubble_ex),   int'(b));
      chk({tag, ".flush_if_id"}, int'(flush_if_id), int'(f));
      chk({tag, ".fwd_a"},       int'(fwd_a),       fa);
      chk({tag, ".fwd_b"},       int'(fwd_b),       fb);
      chk({tag, ".br_busy"},     int'(br_busy),     int'(busy));
      @(posedge clk);
      #1;
   endtask

   task automatic branch_tail(input string tag);
      repeat (3) expect_out({tag, "_wait"}, 1, 1, 0, 0, 0, 1);
      expect_out({tag, "_resume"}, 0, 1, 1, 0, 0, 1);
      nop();
      expect_out({tag, "_idle"}, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      nop();
      @(posedge clk);
      #1;
      expect_out("rst_hold", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      expect_out("rst_idle", 0, 0, 0, 0, 0, 0);

      // add r3,r1,r2 ; add r4,r3,r1
      drive(1, 1, 2, 1, 1, 1, 3, 0, 0);
      expect_out("add_r3", 0, 0, 0, 0, 0, 0);
      drive(1, 3, 1, 1, 1, 1, 4, 0, 0);
`ifdef HAZARD_FWD_EN
      expect_out("raw_fwd", 0, 0, 0, 1, 0, 0);
`else
      repeat (3) expect_out("raw_stall", 1, 1, 0, 0, 0, 0);
      expect_out("raw_issue", 0, 0, 0, 0, 0, 0);
`endif
      nop();
      repeat (3) expect_out("drain1", 0, 0, 0, 0, 0, 0);

      // lw r5,(r1) ; add r6,r5,r5
      drive(1, 1, 2, 1, 0, 1, 5, 1, 0);
      expect_out("lw_r5", 0, 0, 0, 0, 0, 0);
      drive(1, 5, 5, 1, 1, 1, 6, 0, 0);
`ifdef HAZARD_FWD_EN
      expect_out("lu_stall", 1, 1, 0, 0, 0, 0);
      expect_out("lu_fwd", 0, 0, 0, 2, 2, 0);
`else
      repeat (3) expect_out("lu_stall", 1, 1, 0, 0, 0, 0);
      expect_out("lu_issue", 0, 0, 0, 0, 0, 0);
`endif
      nop();
      repeat (3) expect_out("drain2", 0, 0, 0, 0, 0, 0);

      // add r0,r1,r2 ; add r7,r0,r0
      drive(1, 1, 2, 1, 1, 1, 0, 0, 0);
      expect_out("wr_r0", 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 1, 7, 0, 0);
      expect_out("rd_r0", 0, 0, 0, 0, 0, 0);
      nop();
      repeat (3) expect_out("drain3", 0, 0, 0, 0, 0, 0);

      // beq r1,r2 with a wrong-path add r8 sitting in IF_ID
      drive(1, 1, 2, 1, 1, 0, 0, 0, 1);
      expect_out("br_issue", 0, 0, 0, 0, 0, 0);
      drive(1, 1, 2, 1, 1, 1, 8, 0, 0);
      branch_tail("br");

      // add r9 ; beq r9,r1
      drive(1, 1, 2, 1, 1, 1, 9, 0, 0);
      expect_out("add_r9", 0, 0, 0, 0, 0, 0);
      drive(1, 9, 1, 1, 1, 0, 0, 0, 1);
`ifdef HAZARD_FWD_EN
      expect_out("dbr_fwd", 0, 0, 0, 1, 0, 0);
`else
      repeat (3) expect_out("dbr_stall", 1, 1, 0, 0, 0, 0);
      expect_out("dbr_issue", 0, 0, 0, 0, 0, 0);
`endif
      nop();
      branch_tail("dbr");

      // Reset while in BR_WAIT
      drive(1, 1, 2, 1, 1, 0, 0, 0, 1);
      expect_out("rbr_issue", 0, 0, 0, 0, 0, 0);
      nop();
      expect_out("rbr_wait", 1, 1, 0, 0, 0, 1);
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      expect_out("rbr_idle", 0, 0, 0, 0, 0, 0);
      expect_out("rbr_stay", 0, 0, 0, 0, 0, 0);

      // Reset must clear in-flight destinations
      drive(1, 1, 2, 1, 1, 1, 3, 0, 0);
      expect_out("pre_rst_add", 0, 0, 0, 0, 0, 0);
      nop();
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      drive(1, 3, 1, 1, 1, 1, 4, 0, 0);
      expect_out("rst_clr", 0, 0, 0, 0, 0, 0);
      nop();
      expect_out("final_idle", 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
